// File: rtl/subtraction_seq.sv
// Two-cycle split subtractor: out_d = inp_a - inp_b - b_in, low half then high half.
// Define SUB_FLAGS_EN to compute the zero/negative/overflow flags; otherwise they read 0.
module subtraction_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp_a,
  input  logic [WIDTH-1:0] inp_b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_d,
  output logic             out_borrow,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf
);

  localparam int HALF = WIDTH / 2;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic              bin_r;
  logic [HALF-1:0]   d_lo_r;
  logic              c_lo_r;
  logic              accept;
  logic              take;
  logic [HALF:0]     lo_sum;
  logic [HALF:0]     hi_sum;
  logic [WIDTH-1:0]  diff;

  // Handshake: a transfer happens on a rising edge where valid && ready; valid never
  // depends on ready, and a producer holds its data until the transfer happens.
  assign accept = in_valid && in_ready;
  assign take   = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LO;
      LO:      state_nxt = HI;
      HI:      state_nxt = DONE;
      DONE:    if (take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Subtraction as a + ~b + carry; borrow-in inverts into the low carry-in.
  assign lo_sum = {1'b0, a_r[HALF-1:0]} + {1'b0, ~b_r[HALF-1:0]} + {{HALF{1'b0}}, ~bin_r};
  assign hi_sum = {1'b0, a_r[WIDTH-1:HALF]} + {1'b0, ~b_r[WIDTH-1:HALF]} + {{HALF{1'b0}}, c_lo_r};
  assign diff   = {hi_sum[HALF-1:0], d_lo_r};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r        <= '0;
      b_r        <= '0;
      bin_r      <= 1'b0;
      d_lo_r     <= '0;
      c_lo_r     <= 1'b0;
      out_d      <= '0;
      out_borrow <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        a_r   <= inp_a;
        b_r   <= inp_b;
        bin_r <= b_in;
      end
      if (state == LO) begin
        d_lo_r <= lo_sum[HALF-1:0];
        c_lo_r <= lo_sum[HALF];
      end
      if (state == HI) begin
        out_d      <= diff;
        out_borrow <= ~hi_sum[HALF];
      end
    end
  end

`ifdef SUB_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_zero <= 1'b0;
      out_neg  <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (state == HI) begin
      out_zero <= (diff == '0);
      out_neg  <= diff[WIDTH-1];
      out_ovf  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff[WIDTH-1] != a_r[WIDTH-1]);
    end
  end
`else
  assign out_zero = 1'b0;
  assign out_neg  = 1'b0;
  assign out_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_subtraction_seq.sv
// Directed bench for subtraction_seq: arithmetic vectors, latency, backpressure, mid-op reset.
// Flag expectations follow SUB_FLAGS_EN the same way the design does.
module tb_subtraction_seq;

  localparam int WIDTH = 64;
`ifdef SUB_FLAGS_EN
  localparam logic FL = 1'b1;
`else
  localparam logic FL = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] inp_a;
  logic [WIDTH-1:0] inp_b;
  logic             b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_d;
  logic             out_borrow;
  logic             out_zero;
  logic             out_neg;
  logic             out_ovf;

  int    n_checks = 0;
  int    n_fail   = 0;
  string cur_tag  = "reset";

  // Scoreboard entry: {d, borrow, zero, neg, ovf}
  logic [WIDTH+3:0] exp_q[$];
  logic [WIDTH+3:0] exp_e;

  subtraction_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .inp_a      (inp_a),
    .inp_b      (inp_b),
    .b_in       (b_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_d      (out_d),
    .out_borrow (out_borrow),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_ovf    (out_ovf)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input bit ok, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s %s: observed %0h expected %0h", cur_tag, name, obs, exp);
    end
  endtask

  // Issue one operation, check latency and results, optionally hold off the consumer.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic bi, input logic [WIDTH-1:0] ed, input logic eb,
                        input logic ez, input logic en, input logic eo, input int hold);
    cur_tag = tag;
    exp_q.push_back({ed, eb, ez & FL, en & FL, eo & FL});
    chk("in_ready_idle", in_ready === 1'b1, in_ready, 1'b1);
    inp_a    = a;
    inp_b    = b;
    b_in     = bi;
    in_valid = 1'b1;
    @(negedge clk);
    // Accepted on the previous edge; scramble inputs to prove they are not resampled.
    in_valid = 1'b0;
    inp_a    = {$urandom, $urandom};
    inp_b    = ~a;
    b_in     = ~bi;
    chk("valid_lo", out_valid === 1'b0, out_valid, 1'b0);
    chk("ready_lo", in_ready === 1'b0, in_ready, 1'b0);
    @(negedge clk);
    chk("valid_hi", out_valid === 1'b0, out_valid, 1'b0);
    @(negedge clk);
    // Third edge counting the acceptance edge: result is presented.
    chk("valid_done", out_valid === 1'b1, out_valid, 1'b1);
    chk("ready_done", in_ready === 1'b0, in_ready, 1'b0);
    exp_e = exp_q.pop_front();
    chk("d", out_d === exp_e[WIDTH+3:4], out_d, exp_e[WIDTH+3:4]);
    chk("borrow", out_borrow === exp_e[3], out_borrow, exp_e[3]);
    chk("zero", out_zero === exp_e[2], out_zero, exp_e[2]);
    chk("neg", out_neg === exp_e[1], out_neg, exp_e[1]);
    chk("ovf", out_ovf === exp_e[0], out_ovf, exp_e[0]);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      inp_a    = {$urandom, $urandom};
      inp_b    = {$urandom, $urandom};
      @(negedge clk);
      chk("hold_valid", out_valid === 1'b1, out_valid, 1'b1);
      chk("hold_ready", in_ready === 1'b0, in_ready, 1'b0);
      chk("hold_d", out_d === exp_e[WIDTH+3:4], out_d, exp_e[WIDTH+3:4]);
      chk("hold_borrow", out_borrow === exp_e[3], out_borrow, exp_e[3]);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_taken", out_valid === 1'b0, out_valid, 1'b0);
    chk("ready_taken", in_ready === 1'b1, in_ready, 1'b1);
    chk("d_held", out_d === exp_e[WIDTH+3:4], out_d, exp_e[WIDTH+3:4]);
    chk("borrow_held", out_borrow === exp_e[3], out_borrow, exp_e[3]);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    inp_a     = '0;
    inp_b     = '0;
    b_in      = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("valid", out_valid === 1'b0, out_valid, 1'b0);
    chk("d", out_d === 64'h0, out_d, 64'h0);
    chk("borrow", out_borrow === 1'b0, out_borrow, 1'b0);
    chk("zero", out_zero === 1'b0, out_zero, 1'b0);
    chk("neg", out_neg === 1'b0, out_neg, 1'b0);
    chk("ovf", out_ovf === 1'b0, out_ovf, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", in_ready === 1'b1, in_ready, 1'b1);

    //      tag        a                        b                        bin  d                        brw z  n  o  hold
    run_op("10-3",     64'd10,                  64'd3,                   1'b0, 64'd7,                   0, 0, 0, 0, 0);
    run_op("0-1",      64'd0,                   64'd1,                   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1, 0, 0);
    run_op("min-1",    64'h8000_0000_0000_0000, 64'd1,                   1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 0, 1, 0);
    run_op("x-x-1",    64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1, 0, 0);
    run_op("x-x-0",    64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'h0,                   0, 1, 0, 0, 0);
    run_op("half_brw", 64'h0000_0001_0000_0000, 64'd1,                   1'b0, 64'h0000_0000_FFFF_FFFF, 0, 0, 0, 0, 0);
    run_op("backpr",   64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1, 0, 1, 1, 5);

    // Reset pulse while the operation is in the high-half state.
    cur_tag  = "reset_hi";
    inp_a    = 64'd55;
    inp_b    = 64'd11;
    b_in     = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("valid", out_valid === 1'b0, out_valid, 1'b0);
    chk("d", out_d === 64'h0, out_d, 64'h0);
    chk("borrow", out_borrow === 1'b0, out_borrow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_valid", out_valid === 1'b0, out_valid, 1'b0);
      chk("idle_ready", in_ready === 1'b1, in_ready, 1'b1);
    end
    run_op("post_rst", 64'd100,                 64'd58,                  1'b0, 64'd42,                  0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
